pmem_arbiter: RTL and testbench
===============================

// Module: pmem_arbiter
// PURPOSE
// - Two-port arbiter between the I-cache and the D-cache miss/write-back ports and the single physical memory port.
// - The D-cache controller's pmem_read/pmem_write/pmem_resp handshake lands here, so the D-cache must not see a difference from a direct memory connection.
// - Registers the granted request (address, write data, op) so that memory sees stable inputs for the whole transaction.
// - Serves one full-line transaction at a time and picks round-robin on conflicts.
// PARAMETERS
// - ADDR_WIDTH   16    physical address width; matches lc3b_word.
// - LINE_WIDTH   128   cache line / memory transfer width in bits.
// PORTS
// - clk             in   1           single clock; all state changes on posedge.
// - rst_n           in   1           asynchronous, active-low reset.
// - i_pmem_read     in   1           I-cache line-fill request.
// - i_pmem_address  in   ADDR_WIDTH  I-cache line address.
// - i_pmem_rdata    out  LINE_WIDTH  line returned to the I-cache.
// - i_pmem_resp     out  1           I-cache transaction done (1-cycle pulse).
// - d_pmem_read     in   1           D-cache line-fill request.
// - d_pmem_write    in   1           D-cache write-back request.
// - d_pmem_address  in   ADDR_WIDTH  D-cache line address.
// - d_pmem_wdata    in   LINE_WIDTH  D-cache write-back line.
// - d_pmem_rdata    out  LINE_WIDTH  line returned to the D-cache.
// - d_pmem_resp     out  1           D-cache transaction done (1-cycle pulse).
// - pmem_read       out  1           memory read strobe.
// - pmem_write      out  1           memory write strobe.
// - pmem_address    out  ADDR_WIDTH  latched address.
// - pmem_wdata      out  LINE_WIDTH  latched write data.
// - pmem_rdata      in   LINE_WIDTH  memory read data.
// - pmem_resp       in   1           memory done (1-cycle pulse).
// BEHAVIOUR
// - Reset values: state=IDLE, last_grant=D, pmem_read=pmem_write=0, pmem_address=0, pmem_wdata=0, both *_resp=0.
// - Reset is asynchronous: all registers clear immediately on rst_n low, including mid-transaction.
//   - Any in-flight memory access is abandoned and no resp is issued.
// - States:
//   - IDLE: no strobes. Sample requests each cycle.
//     - i_req = i_pmem_read; d_req = d_pmem_read | d_pmem_write.
//     - Only i_req -> SERVE_I. Only d_req -> SERVE_D.
//     - Both -> grant the side opposite to last_grant. The first tie after reset goes to I.
//     - On grant: latch address (and d wdata). Latch op: write if d_pmem_write, else read; d write wins if read and write are both high.
//     - Update last_grant.
//   - SERVE_I / SERVE_D: pmem_read/pmem_write driven from the latched op, held high until pmem_resp.
//     - Requester input changes are ignored while in these states.
//     - On pmem_resp: pulse the granted *_resp the same cycle (combinational), then go to IDLE. Strobes drop next cycle.
// - *_rdata is a combinational pass-through of pmem_rdata to both sides. It is valid only with the matching resp.
// - The non-granted side's resp is always 0. A requester waiting for service sees no resp and keeps asserting its request.
// - Latency: request seen in IDLE -> strobe next cycle.
//   - Total = 1 + memory latency. Minimum 1 idle cycle between back-to-back transactions.
// - Back-to-back D write-back then fill: the fill may be preceded by a pending I request (round-robin). The D-cache tolerates this.
// - A requester dropping its request mid-transaction is a protocol violation. The transaction still completes from the latched copy and resp still pulses.
// - pmem_resp while in IDLE is ignored.
// STRUCTURE
// - Shared package lc3b_types: lc3b_word (16b), lc3b_c_line (128b).
//   - Also pmem_op_t enum {PMEM_READ, PMEM_WRITE} and arb_state_t enum {ARB_IDLE, ARB_SERVE_I, ARB_SERVE_D}.
// - Single module; no sub-module.
//   - Grant choice is a small always_comb block; latch/state in always_ff with async reset.
// TESTING
// - Reset: rst_n=0 mid SERVE_D with pmem_write=1 -> pmem_write=0 immediately, state IDLE, d_pmem_resp stays 0.
// - Lone I fill: i_pmem_read=1, addr=0x1230; memory resp after 3 cycles with rdata=128'hA5...
//   - Required: pmem_read=1, pmem_address=0x1230 one cycle later.
//   - Required: i_pmem_resp pulses 1 cycle with i_pmem_rdata=128'hA5...; d_pmem_resp=0.
// - Simultaneous after reset: i read 0x0040 + d read 0x2000 together.
//   - Required: I served first; D served next with pmem_address=0x2000; exactly one resp per side.
// - Round-robin fairness: both sides request continuously for 6 transactions -> grants alternate I,D,I,D,I,D.
// - D write-back: d_pmem_write=1, addr=0x3FF0, wdata=128'hDEAD...; change d_pmem_address to 0x0000 mid-transaction.
//   - Required: pmem_write=1, pmem_address stays 0x3FF0 and pmem_wdata stays 128'hDEAD... until pmem_resp; d_pmem_resp pulses.
// - Eviction sequence: D write-back 0x1000 then fill 0x2000, with an I request raised during the write.
//   - Required order: D write, I read, D read.
//   - Required: strobes low for ≥1 cycle between transactions; no resp duplicated or lost.

Source files
------------

// File: rtl/pmem_arbiter_pkg.sv
// Shared types for the physical-memory arbiter: word/line types, memory op and arbiter states.
package pmem_arbiter_pkg;

    localparam int PMEM_ADDR_WIDTH = 16;
    localparam int PMEM_LINE_WIDTH = 128;

    typedef logic [PMEM_ADDR_WIDTH-1:0] lc3b_word;
    typedef logic [PMEM_LINE_WIDTH-1:0] lc3b_c_line;

    typedef enum logic {
        PMEM_READ,
        PMEM_WRITE
    } pmem_op_t;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_SERVE_I,
        ARB_SERVE_D
    } arb_state_t;

    // Which requester was granted most recently; drives round-robin on ties.
    typedef enum logic {
        GRANT_I,
        GRANT_D
    } grant_t;

endpackage

// File: rtl/pmem_arbiter.sv
// Arbiter between I-cache and D-cache line ports and a single physical memory port.
// One full-line transaction at a time; the granted request is latched so memory sees
// stable address/data/op until it answers, and ties are broken round-robin.
module pmem_arbiter
    import pmem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = PMEM_ADDR_WIDTH,
    parameter int LINE_WIDTH = PMEM_LINE_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  i_pmem_read,
    input  logic [ADDR_WIDTH-1:0] i_pmem_address,
    output logic [LINE_WIDTH-1:0] i_pmem_rdata,
    output logic                  i_pmem_resp,

    input  logic                  d_pmem_read,
    input  logic                  d_pmem_write,
    input  logic [ADDR_WIDTH-1:0] d_pmem_address,
    input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
    output logic [LINE_WIDTH-1:0] d_pmem_rdata,
    output logic                  d_pmem_resp,

    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [ADDR_WIDTH-1:0] pmem_address,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    input  logic [LINE_WIDTH-1:0] pmem_rdata,
    input  logic                  pmem_resp
);

    arb_state_t            r_state;
    grant_t                r_last_grant;
    pmem_op_t              r_op;
    logic [ADDR_WIDTH-1:0] r_address;
    logic [LINE_WIDTH-1:0] r_wdata;

    logic                  w_i_req;
    logic                  w_d_req;
    logic                  w_grant_i;
    logic                  w_grant_d;
    pmem_op_t              w_d_op;

    assign w_i_req = i_pmem_read;
    assign w_d_req = d_pmem_read | d_pmem_write;

    // A write-back takes priority over a fill if the D-cache raises both at once.
    assign w_d_op  = d_pmem_write ? PMEM_WRITE : PMEM_READ;

    // Pick a winner among requests seen in IDLE; on a tie serve the side that did not go last.
    always_comb begin
        w_grant_i = 1'b0;
        w_grant_d = 1'b0;
        if (w_i_req && w_d_req) begin
            if (r_last_grant == GRANT_D) begin
                w_grant_i = 1'b1;
            end else begin
                w_grant_d = 1'b1;
            end
        end else if (w_i_req) begin
            w_grant_i = 1'b1;
        end else if (w_d_req) begin
            w_grant_d = 1'b1;
        end
    end

    // Transaction FSM: latch the winning request in IDLE, hold it until memory answers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ARB_IDLE;
            r_last_grant <= GRANT_D;
            r_op         <= PMEM_READ;
            r_address    <= '0;
            r_wdata      <= '0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (w_grant_i) begin
                        r_state      <= ARB_SERVE_I;
                        r_last_grant <= GRANT_I;
                        r_op         <= PMEM_READ;
                        r_address    <= i_pmem_address;
                    end else if (w_grant_d) begin
                        r_state      <= ARB_SERVE_D;
                        r_last_grant <= GRANT_D;
                        r_op         <= w_d_op;
                        r_address    <= d_pmem_address;
                        r_wdata      <= d_pmem_wdata;
                    end
                end
                ARB_SERVE_I, ARB_SERVE_D: begin
                    if (pmem_resp) begin
                        r_state <= ARB_IDLE;
                    end
                end
                default: begin
                    r_state <= ARB_IDLE;
                end
            endcase
        end
    end

    // Strobes are decoded purely from registered state, so they never glitch on requester inputs.
    assign pmem_read    = (r_state != ARB_IDLE) && (r_op == PMEM_READ);
    assign pmem_write   = (r_state != ARB_IDLE) && (r_op == PMEM_WRITE);
    assign pmem_address = r_address;
    assign pmem_wdata   = r_wdata;

    // Completion is steered only to the side being served; read data goes to both unconditionally.
    assign i_pmem_resp  = (r_state == ARB_SERVE_I) && pmem_resp;
    assign d_pmem_resp  = (r_state == ARB_SERVE_D) && pmem_resp;
    assign i_pmem_rdata = pmem_rdata;
    assign d_pmem_rdata = pmem_rdata;

endmodule

// File: tb/tb_pmem_arbiter.sv
// Self-checking bench for pmem_arbiter: transaction-level reference model, directed
// scenarios with literal expectations, then a randomized requester/memory phase.
module tb_pmem_arbiter;
    import pmem_arbiter_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         i_pmem_read = 1'b0;
    logic [15:0]  i_pmem_address = '0;
    logic [127:0] i_pmem_rdata;
    logic         i_pmem_resp;
    logic         d_pmem_read = 1'b0;
    logic         d_pmem_write = 1'b0;
    logic [15:0]  d_pmem_address = '0;
    logic [127:0] d_pmem_wdata = '0;
    logic [127:0] d_pmem_rdata;
    logic         d_pmem_resp;
    logic         pmem_read;
    logic         pmem_write;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_wdata;
    logic [127:0] pmem_rdata = '0;
    logic         pmem_resp = 1'b0;

    pmem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
        .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
        .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
        .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
        .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
        .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: who holds memory (0 none, 1 I, 2 D), the latched request, who went last.
    int           mBusy;
    int           mLast;
    logic         mWrite;
    logic [15:0]  mAddr;
    logic [127:0] mWdata;
    int           lastRespSide;
    int           modelRespI = 0;
    int           modelRespD = 0;
    int           dutRespI = 0;
    int           dutRespD = 0;

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic modelReset();
        mBusy = 0;
        mLast = 2;
        mWrite = 1'b0;
        mAddr = '0;
        mWdata = '0;
        lastRespSide = 0;
    endtask

    // Compare every DUT output against what the model says this cycle must look like.
    task automatic compareModel();
        logic expIResp;
        logic expDResp;
        expIResp = (mBusy == 1) && pmem_resp;
        expDResp = (mBusy == 2) && pmem_resp;
        checkOutput("pmem_read", 128'(pmem_read), 128'((mBusy != 0) && !mWrite));
        checkOutput("pmem_write", 128'(pmem_write), 128'((mBusy != 0) && mWrite));
        checkOutput("pmem_address", 128'(pmem_address), 128'(mAddr));
        if (mBusy == 2 && mWrite) checkOutput("pmem_wdata", pmem_wdata, mWdata);
        checkOutput("i_pmem_resp", 128'(i_pmem_resp), 128'(expIResp));
        checkOutput("d_pmem_resp", 128'(d_pmem_resp), 128'(expDResp));
        if (expIResp) checkOutput("i_pmem_rdata", i_pmem_rdata, pmem_rdata);
        if (expDResp) checkOutput("d_pmem_rdata", d_pmem_rdata, pmem_rdata);
        if (i_pmem_resp === 1'b1) dutRespI++;
        if (d_pmem_resp === 1'b1) dutRespD++;
    endtask

    // What the clock edge does at transaction level: finish the current line or grant a new one.
    task automatic advanceModel();
        bit iReq;
        bit dReq;
        int win;
        lastRespSide = 0;
        if (mBusy != 0) begin
            if (pmem_resp) begin
                lastRespSide = mBusy;
                if (mBusy == 1) modelRespI++; else modelRespD++;
                mBusy = 0;
            end
        end else begin
            iReq = i_pmem_read;
            dReq = d_pmem_read || d_pmem_write;
            win = 0;
            if (iReq && dReq) win = (mLast == 2) ? 1 : 2;
            else if (iReq) win = 1;
            else if (dReq) win = 2;
            if (win == 1) begin
                mAddr = i_pmem_address;
                mWrite = 1'b0;
            end else if (win == 2) begin
                mAddr = d_pmem_address;
                mWrite = d_pmem_write;
                mWdata = d_pmem_wdata;
            end
            if (win != 0) begin
                mBusy = win;
                mLast = win;
            end
        end
    endtask

    // One cycle: inputs were driven at the negedge; sample, compare, advance model, wait.
    task automatic step();
        #1;
        compareModel();
        advanceModel();
        @(negedge clk);
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        i_pmem_read = 1'b0;
        d_pmem_read = 1'b0;
        d_pmem_write = 1'b0;
        pmem_resp = 1'b0;
        #1;
        modelReset();
        checkOutput("reset_pmem_read", 128'(pmem_read), 128'd0);
        checkOutput("reset_pmem_write", 128'(pmem_write), 128'd0);
        checkOutput("reset_pmem_address", 128'(pmem_address), 128'd0);
        checkOutput("reset_pmem_wdata", pmem_wdata, 128'd0);
        checkOutput("reset_resps", 128'({i_pmem_resp, d_pmem_resp}), 128'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Act as memory for one transaction: wait for a grant, answer after lat strobe cycles.
    task automatic serveOne(input int lat, input logic [127:0] data, input bit dropAfter,
                            output int side, output logic [15:0] addr, output logic wr);
        side = 0;
        addr = '0;
        wr = 1'b0;
        for (int n = 0; n < 20 && mBusy == 0; n++) step();
        if (mBusy == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL grant_timeout actual=no_grant required=grant");
            return;
        end
        for (int n = 1; n < lat; n++) step();
        pmem_resp = 1'b1;
        pmem_rdata = data;
        side = mBusy;
        addr = pmem_address;
        wr = pmem_write;
        step();
        pmem_resp = 1'b0;
        if (dropAfter) begin
            if (side == 1) i_pmem_read = 1'b0;
            if (side == 2) begin
                d_pmem_read = 1'b0;
                d_pmem_write = 1'b0;
            end
        end
        #1;
        checkOutput("gap_strobes", 128'({pmem_read, pmem_write}), 128'd0);
    endtask

    // Random cache-like requesters and a memory with random latency and stray resp pulses.
    task automatic applyStimulus();
        int r;
        if (lastRespSide == 1) i_pmem_read = 1'b0;
        else if (!i_pmem_read && $urandom_range(0, 2) == 0) begin
            i_pmem_read = 1'b1;
            i_pmem_address = 16'($urandom);
        end
        if (lastRespSide == 2) begin
            d_pmem_read = 1'b0;
            d_pmem_write = 1'b0;
        end else if (!(d_pmem_read || d_pmem_write) && $urandom_range(0, 2) == 0) begin
            r = int'($urandom_range(0, 7));
            d_pmem_write = (r < 3) || (r == 7);
            d_pmem_read = (r >= 3);
            d_pmem_address = 16'($urandom);
            d_pmem_wdata = {$urandom, $urandom, $urandom, $urandom};
        end
        if (mBusy == 1 && $urandom_range(0, 3) == 0) i_pmem_address = 16'($urandom);
        if (mBusy == 2 && $urandom_range(0, 3) == 0) begin
            d_pmem_address = 16'($urandom);
            d_pmem_wdata = {$urandom, $urandom, $urandom, $urandom};
        end
        pmem_resp = (mBusy != 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
        pmem_rdata = {$urandom, $urandom, $urandom, $urandom};
    endtask

    initial begin
        int side;
        logic [15:0] addr;
        logic wr;
        int snapI;
        int snapD;
        int expSide;

        modelReset();
        doReset();

        // Lone I fill at 0x1230, memory answers in the third strobe cycle.
        i_pmem_read = 1'b1;
        i_pmem_address = 16'h1230;
        step();
        checkOutput("lone_i_strobe", 128'(pmem_read), 128'd1);
        checkOutput("lone_i_addr", 128'(pmem_address), 128'h1230);
        step();
        step();
        pmem_resp = 1'b1;
        pmem_rdata = {16{8'hA5}};
        #1;
        checkOutput("lone_i_resp", 128'(i_pmem_resp), 128'd1);
        checkOutput("lone_i_rdata", i_pmem_rdata, {16{8'hA5}});
        checkOutput("lone_i_d_resp", 128'(d_pmem_resp), 128'd0);
        step();
        pmem_resp = 1'b0;
        i_pmem_read = 1'b0;
        step();
        checkOutput("lone_i_drop", 128'(pmem_read), 128'd0);

        // Simultaneous requests right after reset: I first, then D, one resp each.
        doReset();
        snapI = dutRespI;
        snapD = dutRespD;
        i_pmem_read = 1'b1;
        i_pmem_address = 16'h0040;
        d_pmem_read = 1'b1;
        d_pmem_address = 16'h2000;
        serveOne(2, {4{32'h11111111}}, 1'b1, side, addr, wr);
        checkOutput("tie_first_side", 128'(side), 128'd1);
        checkOutput("tie_first_addr", 128'(addr), 128'h0040);
        serveOne(2, {4{32'h22222222}}, 1'b1, side, addr, wr);
        checkOutput("tie_second_side", 128'(side), 128'd2);
        checkOutput("tie_second_addr", 128'(addr), 128'h2000);
        repeat (3) step();
        checkOutput("tie_i_resp_count", 128'(dutRespI - snapI), 128'd1);
        checkOutput("tie_d_resp_count", 128'(dutRespD - snapD), 128'd1);

        // Round-robin with both sides requesting continuously.
        doReset();
        i_pmem_read = 1'b1;
        i_pmem_address = 16'h0100;
        d_pmem_read = 1'b1;
        d_pmem_address = 16'h0200;
        for (int k = 0; k < 6; k++) begin
            serveOne(1 + k % 3, {4{$urandom}}, 1'b0, side, addr, wr);
            expSide = (k % 2 == 0) ? 1 : 2;
            checkOutput("rr_side", 128'(side), 128'(expSide));
        end
        i_pmem_read = 1'b0;
        d_pmem_read = 1'b0;
        step();

        // D write-back with the requester address changing mid-transaction.
        doReset();
        d_pmem_write = 1'b1;
        d_pmem_address = 16'h3FF0;
        d_pmem_wdata = {8{16'hDEAD}};
        step();
        checkOutput("wb_strobe", 128'(pmem_write), 128'd1);
        d_pmem_address = 16'h0000;
        d_pmem_wdata = '0;
        step();
        step();
        checkOutput("wb_addr_held", 128'(pmem_address), 128'h3FF0);
        checkOutput("wb_wdata_held", pmem_wdata, {8{16'hDEAD}});
        pmem_resp = 1'b1;
        #1;
        checkOutput("wb_d_resp", 128'(d_pmem_resp), 128'd1);
        step();
        pmem_resp = 1'b0;
        d_pmem_write = 1'b0;
        step();

        // Asynchronous reset in the middle of a D write-back.
        d_pmem_write = 1'b1;
        d_pmem_address = 16'h0ABC;
        step();
        step();
        #2;
        rst_n = 1'b0;
        pmem_resp = 1'b1;
        #1;
        checkOutput("async_rst_write", 128'(pmem_write), 128'd0);
        checkOutput("async_rst_d_resp", 128'(d_pmem_resp), 128'd0);
        checkOutput("async_rst_addr", 128'(pmem_address), 128'd0);
        modelReset();
        pmem_resp = 1'b0;
        d_pmem_write = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Eviction: D write 0x1000, I raised during it, then D fill 0x2000.
        doReset();
        d_pmem_write = 1'b1;
        d_pmem_address = 16'h1000;
        d_pmem_wdata = {4{32'hCAFEF00D}};
        step();
        i_pmem_read = 1'b1;
        i_pmem_address = 16'h0500;
        serveOne(3, '0, 1'b0, side, addr, wr);
        checkOutput("evict_1_side", 128'(side), 128'd2);
        checkOutput("evict_1_write", 128'(wr), 128'd1);
        d_pmem_write = 1'b0;
        d_pmem_read = 1'b1;
        d_pmem_address = 16'h2000;
        serveOne(2, {4{32'h0BADBEEF}}, 1'b1, side, addr, wr);
        checkOutput("evict_2_side", 128'(side), 128'd1);
        serveOne(2, {4{32'h12345678}}, 1'b1, side, addr, wr);
        checkOutput("evict_3_side", 128'(side), 128'd2);
        checkOutput("evict_3_addr", 128'(addr), 128'h2000);
        checkOutput("evict_3_write", 128'(wr), 128'd0);
        step();

        // Randomized traffic against the model.
        doReset();
        for (int c = 0; c < 2000; c++) begin
            applyStimulus();
            step();
        end
        pmem_resp = 1'b0;
        checkOutput("total_i_resps", 128'(dutRespI), 128'(modelRespI));
        checkOutput("total_d_resps", 128'(dutRespD), 128'(modelRespD));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
